mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port main-memory arbiter between the instruction cache (refill, read-only) and the data cache (refill reads, write-through single-word writes). It owns the single backing-memory port behind both caches, serialises transactions, and sequences read bursts of BURST_LEN words. A requester waiting on this block is the source of its cache's stall signal (`mem_stall` on the data side) toward the core.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `BURST_LEN`, 4, words per read burst (power of two, ≥1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `i_req`  in  1  icache refill request; held until `i_done`
- `i_addr`  in  ADDR_WIDTH  icache refill byte address
- `i_rvalid`  out  1  read beat valid to icache
- `i_rdata`  out  DATA_WIDTH  read beat data
- `i_done`  out  1  one-cycle pulse, icache transaction complete
- `d_req`  in  1  dcache request; held until `d_done`
- `d_we`  in  1  1 = single-word write, 0 = burst read
- `d_addr`  in  ADDR_WIDTH  dcache byte address
- `d_wdata`  in  DATA_WIDTH  write data
- `d_wstrb`  in  4  byte enables for write
- `d_rvalid`, `d_rdata`, `d_done`  out  1/DATA_WIDTH/1  as icache equivalents
- `mem_req`  out  1  memory transaction beat pending
- `mem_we`  out  1  beat is a write
- `mem_addr`  out  ADDR_WIDTH  beat byte address
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_wstrb`  out  4  byte enables (0000 on reads)
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completes current beat this cycle
- `busy`  out  1  state != IDLE
- `owner`  out  1  0 = icache, 1 = dcache; valid while `busy`

## Operation
- States: IDLE, ACTIVE.
- IDLE: if any req, pick owner, latch addr/we/wdata/wstrb, clear beat counter, go ACTIVE. Else stay.
- Arbitration: single requester wins. On a tie, grant the requester not granted last (`last_owner` register). `last_owner` resets to dcache, so the icache wins the first tie.
- The icache is always a read burst. A dcache request with `d_we`=0 is a read burst; with `d_we`=1 it is one write beat.
- ACTIVE: `mem_req`=1.
  - `mem_addr` = {latched addr with low log2(BURST_LEN*4) bits cleared, beat, 2'b00} for reads.
  - For writes, `mem_addr` = latched addr with bits [1:0] cleared.
  - Beat counter is log2(BURST_LEN) bits, counting 0..BURST_LEN-1. Beats are issued in ascending order; there is no critical-word-first and no wrap.
- On `mem_ready` in ACTIVE:
  - Read: owner's `rvalid`=1 and `rdata`=`mem_rdata`, combinational same cycle; beat increments.
  - Last beat (beat==BURST_LEN-1, or any write): owner's `done`=1 same cycle, `last_owner` updated, next state IDLE.
- Non-owner `rvalid`/`done` stay 0. `rdata` outputs may carry `mem_rdata` at all times; consumers qualify with `rvalid`.
- `mem_ready` in IDLE is ignored.
- Requester rule: `req` must drop on the edge after `done`, which holds for a registered requester. A req still high in the IDLE cycle after `done` is treated as a new request.
- Request inputs that change while ACTIVE are ignored; latched values are used.

## Timing
- Reset (`rst`=0 at edge): state IDLE, beat 0, `last_owner`=1. All outputs 0: `mem_req`, `mem_we`, `mem_wstrb`, `busy`, all `rvalid`/`done`. Address/data outputs are 0.
- Reset mid-transaction: transaction is abandoned. `mem_req` drops after that edge, no `done` is issued, and the requester must re-request.
- Req sampled in IDLE at cycle t → `mem_req`=1 from t+1.
- Minimum latency, ready immediately:
  - Write: `done` at t+1.
  - Read: `done` at t+BURST_LEN.
- Back-to-back: after `done` at cycle u, state is IDLE at u+1; next grant at u+1, with `mem_req` at u+2. There is one dead cycle per transaction.
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` are stable while ACTIVE until `mem_ready`. They change only after a beat completes.
- Memory may hold `mem_ready` low for any number of cycles; there is no timeout.

## Test plan
- Icache refill alone, `i_addr`=0x104, `mem_ready` always 1 → `mem_addr` 0x100, 0x104, 0x108, 0x10C on consecutive cycles. `i_rvalid` high 4 cycles with `mem_rdata`, `i_done` on the 4th, `d_*` outputs all 0.
- Dcache write, `d_addr`=0x2002, `d_wdata`=0xDEADBEEF, `d_wstrb`=0011 → one cycle with `mem_we`=1, `mem_addr`=0x2000, `mem_wstrb`=0011. `d_done` on that cycle; `d_rvalid` stays 0.
- Simultaneous `i_req`/`d_req` out of reset → icache served first, dcache granted the cycle after `i_done`. A following tie grants the dcache, then the icache.
- Read with `mem_ready` inserting 3 wait cycles per beat → address held constant during the waits. `i_done` at cycle t+16 after grant, `busy` high throughout.
- `rst` low during beat 2 of a burst → next cycle `mem_req`=0, `busy`=0, no `done`. A re-issued request restarts at beat 0 with the base address.
- `mem_ready` pulsed while IDLE → no `rvalid`/`done` outputs, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Owns the single backing-memory port shared by the instruction cache (refill
// reads only) and the data cache (refill reads and write-through single-word
// writes). One transaction is in flight at a time. Reads are BURST_LEN-word
// bursts issued in ascending address order from the line base. Writes are a
// single beat. A requester holds its req until it sees its done pulse, so a
// waiting requester is what stalls its cache toward the core.
//
// Ports
//   clk                 single clock, all state on the rising edge
//   rst                 synchronous reset, active low
//   i_req/i_addr        icache refill request and byte address
//   i_rvalid/i_rdata    icache read beat strobe and data
//   i_done              icache transaction-complete pulse
//   d_req/d_we/d_addr   dcache request, write flag, byte address
//   d_wdata/d_wstrb     dcache write data and byte enables
//   d_rvalid/d_rdata    dcache read beat strobe and data
//   d_done              dcache transaction-complete pulse
//   mem_req/mem_we      memory beat pending and its direction
//   mem_addr            memory beat byte address (word aligned)
//   mem_wdata/mem_wstrb memory write data and byte enables (0000 on reads)
//   mem_rdata/mem_ready memory read data and beat-complete handshake
//   busy                a transaction is in flight
//   owner               0 = icache, 1 = dcache; meaningful while busy
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,

  output logic                  busy,
  output logic                  owner
);

  // A one-word burst still needs a one-bit counter; it simply never advances.
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  // Clears the byte offset inside one burst-sized line.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN * 4 - 1);

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Request payload captured at grant; inputs are ignored while ACTIVE.
  logic                  owner_q;
  logic                  last_owner;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [BEAT_W-1:0]     beat_q;

  // Per-cycle beat events, decoded in the FSM output block.
  logic                  beat_xfer;   // a beat completes this cycle
  logic                  beat_last;   // that beat ends the transaction

  // Arbitration: a lone requester wins; on a tie the side not granted last
  // wins. Only consulted in IDLE.
  logic any_req;
  logic grant_d;

  assign any_req = i_req | d_req;
  assign grant_d = d_req & (~i_req | (last_owner == OWNER_I));

  assign busy  = (state == ACTIVE);
  assign owner = owner_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    beat_xfer = 1'b0;
    beat_last = 1'b0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_done    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;

    unique case (state)
      IDLE: begin
        // mem_ready is ignored here: no beat is outstanding.
        if (any_req) begin
          state_nxt = ACTIVE;
        end
      end

      ACTIVE: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (we_q) begin
          mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata = wdata_q;
          mem_wstrb = wstrb_q;
        end else begin
          // Line base plus beat index; ascending, no wrap.
          mem_addr = (addr_q & LINE_MASK) | (ADDR_WIDTH'(beat_q) << 2);
        end

        if (mem_ready) begin
          beat_xfer = 1'b1;
          beat_last = we_q || (beat_q == LAST_BEAT);
          if (beat_last) begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Route beat strobes to the owner only; data is qualified by rvalid.
    if (beat_xfer && !we_q) begin
      if (owner_q == OWNER_I) begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
    end
    if (beat_last) begin
      if (owner_q == OWNER_I) begin
        i_done = 1'b1;
      end else begin
        d_done = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant capture, beat counter and arbitration history
  // ---------------------------------------------------------------------------
  // NOTE: the captured payload is reset along with the control state. It is
  // invisible outside ACTIVE, but resetting it keeps simulation free of X
  // and makes an abandoned transaction leave nothing behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q    <= OWNER_I;
      last_owner <= OWNER_D;    // icache wins the first tie
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      beat_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= grant_d;
            beat_q  <= '0;
            if (grant_d) begin
              we_q    <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              wstrb_q <= d_wstrb;
            end else begin
              we_q    <= 1'b0;      // icache is always a read burst
              addr_q  <= i_addr;
              wdata_q <= '0;
              wstrb_q <= 4'b0000;
            end
          end
        end

        ACTIVE: begin
          if (beat_xfer) begin
            if (beat_last) begin
              last_owner <= owner_q;
              beat_q     <= '0;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Stimulus tasks push the expected memory
// beats (address, direction, strobes, owner, last) into a scoreboard queue in
// the order the arbiter must serve them; an independent monitor pops one entry
// on every completed beat and compares the memory-side and cache-side outputs.
// A small memory responder returns address-derived data and can insert a fixed
// number of wait cycles per beat.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 4;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;
  logic          owner;

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BURST_LEN (BL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: data is a fixed function of the beat address; ready
  // arrives after wait_n stall cycles; idle_pulse forces ready regardless.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  int       wait_n     = 0;
  logic     idle_pulse = 1'b0;
  logic [3:0] wcnt     = 4'd0;

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 4'd0;
    else                       wcnt <= wcnt + 4'd1;
  end

  assign mem_rdata = mem_model(mem_addr);
  assign mem_ready = idle_pulse | (mem_req && (int'(wcnt) == wait_n));

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        last;
  } exp_t;

  exp_t sb[$];

  task automatic push_read(input logic own, input logic [31:0] base);
    for (int k = 0; k < BL; k++)
      sb.push_back('{own, 1'b0, base + 32'(4 * k), 4'b0000, 32'h0, (k == BL - 1)});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    sb.push_back('{1'b1, 1'b1, a, ws, wd, 1'b1});
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req && mem_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("mem_addr",  mem_addr,  e.addr);
          check("mem_we",    32'(mem_we),    32'(e.we));
          check("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          check("owner",     32'(owner),    32'(e.own));
          check("busy",      32'(busy),     32'd1);
          check("i_rvalid",  32'(i_rvalid), 32'(!e.own && !e.we));
          check("i_done",    32'(i_done),   32'(!e.own && e.last));
          check("d_rvalid",  32'(d_rvalid), 32'(e.own && !e.we));
          check("d_done",    32'(d_done),   32'(e.own && e.last));
          if (!e.we && !e.own) check("i_rdata", i_rdata, mem_model(e.addr));
          if (!e.we &&  e.own) check("d_rdata", d_rdata, mem_model(e.addr));
        end
      end else begin
        check("stray_strobe", {28'h0, i_rvalid, i_done, d_rvalid, d_done}, 32'h0);
        if (mem_req && sb.size() > 0) check("addr_hold", mem_addr, sb[0].addr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Requester tasks
  // ---------------------------------------------------------------------------
  task automatic wait_done(input logic side, output int at);
    bit seen = 1'b0;
    at = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (side ? d_done : i_done) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    if (!seen) check(side ? "d_done_timeout" : "i_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_i(input logic [31:0] a, output int t, output int u);
    @(negedge clk);
    i_addr = a;
    i_req  = 1'b1;
    t      = cyc;
    wait_done(1'b0, u);
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  task automatic run_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output int t, output int u);
    @(negedge clk);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_wstrb = ws;
    d_req   = 1'b1;
    t       = cyc;
    wait_done(1'b1, u);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t, u, i1, d1, i2;
    bit ok;

    rst = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_strobes",   {28'h0, i_rvalid, i_done, d_rvalid, d_done}, 32'h0);
    rst = 1'b1;

    // Icache refill alone, zero wait states.
    push_read(1'b0, 32'h0000_0100);
    run_i(32'h0000_0104, t, u);
    check("i_read_latency", 32'(u - t), 32'd4);

    // Dcache single write.
    push_write(32'h0000_2000, 32'hDEAD_BEEF, 4'b0011);
    run_d(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 4'b0011, t, u);
    check("d_write_latency", 32'(u - t), 32'd1);

    // Tie out of reset: icache, then dcache (icache re-requests so the second
    // decision is also a tie), then icache.
    apply_reset();
    push_read(1'b0, 32'h0000_0300);
    push_write(32'h0000_3004, 32'h1234_5678, 4'b1111);
    push_read(1'b0, 32'h0000_0400);
    @(negedge clk);
    fork
      begin
        i_addr = 32'h0000_0308;
        i_req  = 1'b1;
        wait_done(1'b0, i1);
        @(posedge clk);
        #1 i_addr = 32'h0000_0404;
        wait_done(1'b0, i2);
        @(posedge clk);
        #1 i_req = 1'b0;
      end
      begin
        d_we    = 1'b1;
        d_addr  = 32'h0000_3006;
        d_wdata = 32'h1234_5678;
        d_wstrb = 4'b1111;
        d_req   = 1'b1;
        wait_done(1'b1, d1);
        @(posedge clk);
        #1 d_req = 1'b0;
      end
    join
    check("tie_d_after_i", 32'(d1 - i1), 32'd2);
    check("tie_i_after_d", 32'(i2 - d1), 32'd5);

    // Read with 3 wait cycles per beat; busy must never drop.
    wait_n = 3;
    push_read(1'b0, 32'h0000_0140);
    @(negedge clk);
    i_addr = 32'h0000_0148;
    i_req  = 1'b1;
    t      = cyc;
    u      = -1;
    ok     = 1'b1;
    for (int k = 0; k < 100 && u < 0; k++) begin
      @(negedge clk);
      if (!busy) ok = 1'b0;
      if (i_done) u = cyc;
    end
    if (u < 0) check("i_wait_timeout", 32'd0, 32'd1);
    else       check("i_wait_latency", 32'(u - t), 32'd16);
    check("busy_throughout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 i_req = 1'b0;
    wait_n = 0;

    // Reset during beat 2: beats 0..2 appear, then the burst is abandoned.
    for (int k = 0; k < 3; k++)
      sb.push_back('{1'b0, 1'b0, 32'h0000_0200 + 32'(4 * k), 4'b0000, 32'h0, 1'b0});
    @(negedge clk);
    i_addr = 32'h0000_0208;
    i_req  = 1'b1;
    ok     = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h0000_0208) ok = 1'b1;
    end
    check("beat2_reached", 32'(ok), 32'd1);
    #1;
    rst   = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_no_done", {30'h0, i_done, d_done}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    push_read(1'b0, 32'h0000_0200);
    run_i(32'h0000_0208, t, u);
    check("restart_latency", 32'(u - t), 32'd4);

    // mem_ready pulsed while idle must be ignored.
    @(negedge clk);
    idle_pulse = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy",    32'(busy),    32'd0);
      check("idle_mem_req", 32'(mem_req), 32'd0);
    end
    idle_pulse = 1'b0;

    // Dcache read burst.
    push_read(1'b1, 32'h0000_5000);
    run_d(1'b0, 32'h0000_5008, 32'h0, 4'b0000, t, u);
    check("d_read_latency", 32'(u - t), 32'd4);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
